// File: rtl/sd4_mac_pkg.sv
// Shared SD4 MAC datapath definitions: default widths, accumulator FSM states and
// partial-product sign extension.
package sd4_mac_pkg;

    localparam int unsigned DEF_PP_W  = 16;
    localparam int unsigned DEF_EXP_W = 5;
    localparam int unsigned DEF_ACC_W = 20;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } acc_state_t;

    function automatic logic signed [DEF_ACC_W-1:0] sext_pp(
        input logic signed [DEF_PP_W-1:0] pp
    );
        return {{(DEF_ACC_W-DEF_PP_W){pp[DEF_PP_W-1]}}, pp};
    endfunction

endpackage

// File: rtl/acc_sat_clamp.sv
// Combinational signed clamp from IN_W down to the OUT_W range, with a flag raised
// whenever the input lies outside that range.
module acc_sat_clamp #(
    parameter int unsigned IN_W  = 20,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  in_val,
    output logic signed [OUT_W-1:0] out_val,
    output logic                    sat
);

    // Value fits when every bit from the OUT_W sign bit upward agrees.
    logic [IN_W-OUT_W:0] top_bits;

    always_comb begin
        top_bits = in_val[IN_W-1:OUT_W-1];
        sat      = (|top_bits) && !(&top_bits);
        if (!sat) begin
            out_val = in_val[OUT_W-1:0];
        end else if (in_val[IN_W-1]) begin
            out_val = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            out_val = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/aligned_pp_accumulator.sv
// Sums groups of aligned signed partial products and hands one registered result per
// group downstream. Define ACC_SAT_EN to clamp each group sum to the signed OUT_W range.
module aligned_pp_accumulator
    import sd4_mac_pkg::*;
#(
    parameter int unsigned PP_W      = DEF_PP_W,
    parameter int unsigned EXP_W     = DEF_EXP_W,
    parameter int unsigned ACC_W     = DEF_ACC_W,
    parameter int unsigned MAX_TERMS = 16,
    parameter int unsigned CNT_W     = 5,
    parameter int unsigned OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [PP_W-1:0]  in_pp,
    input  logic [EXP_W-1:0]        in_exp_max,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [EXP_W-1:0]        out_exp,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_err,
    output logic                    out_sat
);

    if ((ACC_W < PP_W + $clog2(MAX_TERMS)) || (OUT_W > ACC_W) ||
        ((2 ** CNT_W) <= MAX_TERMS)) begin : g_param_check
        $error("aligned_pp_accumulator: inconsistent width parameters");
    end

    acc_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_nxt;
    logic [EXP_W-1:0]        exp_q, exp_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    rdy_q;
    logic                    beat;
    logic                    enter_hold;

    assign beat       = in_valid && rdy_q;
    assign enter_hold = (state_q != HOLD) && (state_d == HOLD);

    always_comb begin
        state_d = state_q;
        acc_nxt = acc_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_nxt = sext_pp(in_pp);
                    exp_d   = in_exp_max;
                    cnt_d   = CNT_W'(1);
                    err_d   = 1'b0;
                    state_d = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_nxt = acc_q + sext_pp(in_pp);
                    cnt_d   = cnt_q + 1'b1;
                    if (in_exp_max != exp_q) begin
                        err_d = 1'b1;
                    end
                    if (in_last || (cnt_d == CNT_W'(MAX_TERMS))) begin
                        state_d = HOLD;
                        // Closing on the term limit without in_last is a forced close.
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ACC_SAT_EN
    logic signed [OUT_W-1:0] clamp_val;
    logic                    clamp_hit;
    logic                    sat_q, sat_d;

    acc_sat_clamp #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_clamp (
        .in_val  (acc_nxt),
        .out_val (clamp_val),
        .sat     (clamp_hit)
    );

    assign acc_d = enter_hold ? {{(ACC_W-OUT_W){clamp_val[OUT_W-1]}}, clamp_val} : acc_nxt;
    assign sat_d = enter_hold ? clamp_hit : sat_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign out_sat = sat_q;
`else
    assign acc_d   = acc_nxt;
    assign out_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            // Registered so in_ready stays low during reset and rises one cycle after.
            rdy_q   <= (state_d != HOLD);
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_exp   = exp_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_aligned_pp_accumulator.sv
// Randomized and directed bench for aligned_pp_accumulator against a group-level model.
// Honours ACC_SAT_EN the same way as the design.
module tb_aligned_pp_accumulator;

    localparam int MAX_TERMS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_pp = '0;
    logic [4:0]  in_exp_max = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_sum;
    logic [4:0]  out_exp;
    logic [4:0]  out_count;
    logic        out_err;
    logic        out_sat;

    int n_checks = 0;
    int n_errors = 0;

    // Group-level reference model
    int          g_pp[$];
    int          g_exp[$];
    bit          m_pend = 1'b0;
    logic [19:0] m_sum;
    logic [4:0]  m_exp, m_cnt;
    logic        m_err, m_sat;
    logic [19:0] last_sum;
    logic [4:0]  last_exp, last_cnt;
    logic        last_err, last_sat;
    int          n_groups = 0;

    aligned_pp_accumulator u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pp      (in_pp),
        .in_exp_max (in_exp_max),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_exp    (out_exp),
        .out_count  (out_count),
        .out_err    (out_err),
        .out_sat    (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic close_group(input bit by_last);
        int s;
        s     = 0;
        m_err = !by_last;
        foreach (g_pp[i]) begin
            s += g_pp[i];
            if (g_exp[i] != g_exp[0]) m_err = 1'b1;
        end
        m_sat = 1'b0;
`ifdef ACC_SAT_EN
        if (s > 32767) begin
            s = 32767;
            m_sat = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            m_sat = 1'b1;
        end
`endif
        m_sum  = s[19:0];
        m_exp  = g_exp[0][4:0];
        m_cnt  = 5'(g_pp.size());
        m_pend = 1'b1;
        g_pp.delete();
        g_exp.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_in_ready", 32'(in_ready), 0);
            check_eq("rst_out_valid", 32'(out_valid), 0);
            check_eq("rst_out_sum", 32'(out_sum), 0);
            check_eq("rst_out_count", 32'(out_count), 0);
            check_eq("rst_out_err", 32'(out_err), 0);
            g_pp.delete();
            g_exp.delete();
            m_pend = 1'b0;
        end else begin
            check_eq("in_ready", 32'(in_ready), 32'(!m_pend));
            check_eq("out_valid", 32'(out_valid), 32'(m_pend));
            if (m_pend) begin
                check_eq("out_sum", 32'(out_sum), 32'(m_sum));
                check_eq("out_exp", 32'(out_exp), 32'(m_exp));
                check_eq("out_count", 32'(out_count), 32'(m_cnt));
                check_eq("out_err", 32'(out_err), 32'(m_err));
                check_eq("out_sat", 32'(out_sat), 32'(m_sat));
                if (out_ready) begin
                    m_pend   = 1'b0;
                    last_sum = m_sum;
                    last_exp = m_exp;
                    last_cnt = m_cnt;
                    last_err = m_err;
                    last_sat = m_sat;
                    n_groups++;
                end
            end else if (in_valid) begin
                g_pp.push_back(int'($signed(in_pp)));
                g_exp.push_back(int'(in_exp_max));
                if (in_last || g_pp.size() == MAX_TERMS) close_group(in_last);
            end
        end
    end

    task automatic cyc(input bit v, input logic [15:0] pp, input logic [4:0] e,
                       input bit l, input bit r);
        in_valid   = v;
        in_pp      = pp;
        in_exp_max = e;
        in_last    = l;
        out_ready  = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int groups_before;

        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Four equal beats
        repeat (3) cyc(1, 16'h4000, 5'd3, 0, 1);
        cyc(1, 16'h4000, 5'd3, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
`ifdef ACC_SAT_EN
        check_eq("s1_sum", 32'(last_sum), 32'h07FFF);
        check_eq("s1_sat", 32'(last_sat), 1);
`else
        check_eq("s1_sum", 32'(last_sum), 32'h10000);
        check_eq("s1_sat", 32'(last_sat), 0);
`endif
        check_eq("s1_exp", 32'(last_exp), 3);
        check_eq("s1_cnt", 32'(last_cnt), 4);
        check_eq("s1_err", 32'(last_err), 0);

        // Cancelling pair, then a single-beat group
        cyc(1, 16'h4000, 5'd7, 0, 1);
        cyc(1, 16'hC000, 5'd7, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s2_zero", 32'(last_sum), 0);
        cyc(1, 16'hFFFF, 5'd1, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s2_neg1", 32'(last_sum), 32'hFFFFF);
        check_eq("s2_cnt", 32'(last_cnt), 1);

        // Back-pressure in HOLD with in_valid held high
        cyc(1, 16'h0123, 5'd2, 0, 0);
        cyc(1, 16'h0100, 5'd2, 1, 0);
        repeat (5) cyc(1, 16'h0055, 5'd2, 1, 0);
        cyc(1, 16'h0055, 5'd2, 1, 1);
        cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s3_sum", 32'(last_sum), 32'h00223);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);

        // Exponent mismatch, then forced close and a following group
        cyc(1, 16'h0100, 5'd3, 0, 1);
        cyc(1, 16'h0100, 5'd4, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s4_mm_sum", 32'(last_sum), 32'h00200);
        check_eq("s4_mm_err", 32'(last_err), 1);
        repeat (16) cyc(1, 16'h0001, 5'd2, 0, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s4_fc_cnt", 32'(last_cnt), 16);
        check_eq("s4_fc_err", 32'(last_err), 1);
        check_eq("s4_fc_sum", 32'(last_sum), 32'h00010);
        cyc(1, 16'h0005, 5'd2, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s4_next_cnt", 32'(last_cnt), 1);
        check_eq("s4_next_sum", 32'(last_sum), 32'h00005);

        // Sixteenth beat carrying in_last is a normal close
        repeat (15) cyc(1, 16'h0002, 5'd6, 0, 1);
        cyc(1, 16'h0002, 5'd6, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s4_last16_err", 32'(last_err), 0);
        check_eq("s4_last16_cnt", 32'(last_cnt), 16);

        // Asynchronous reset mid-group
        groups_before = n_groups;
        repeat (2) cyc(1, 16'h0777, 5'd3, 0, 1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("s5_async_valid", 32'(out_valid), 0);
        check_eq("s5_async_ready", 32'(in_ready), 0);
        check_eq("s5_async_sum", 32'(out_sum), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("s5_no_result", 32'(n_groups), 32'(groups_before));
        cyc(1, 16'h0010, 5'd3, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
        check_eq("s5_fresh_sum", 32'(last_sum), 32'h00010);

        // Saturating-range beats
        repeat (3) cyc(1, 16'h8000, 5'd1, 0, 1);
        cyc(1, 16'h8000, 5'd1, 1, 1);
        repeat (2) cyc(0, 16'h0, 5'd0, 0, 1);
`ifdef ACC_SAT_EN
        check_eq("s6_neg_sum", 32'(last_sum), 32'hF8000);
        check_eq("s6_neg_sat", 32'(last_sat), 1);
`else
        check_eq("s6_neg_sum", 32'(last_sum), 32'hE0000);
        check_eq("s6_neg_sat", 32'(last_sat), 0);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 3) != 0),
                16'($urandom),
                ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'd3,
                ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 1) == 1));
        end
        repeat (3) cyc(0, 16'h0, 5'd0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
